// File: rtl/wb_cmd_master_if.sv
// ---------------------------------------------------------------------------
// wb_cmd_master_if
//   Signal bundle for wb_cmd_master: the valid/ready command port, the
//   valid/ready response port and the Wishbone classic initiator signals.
//   Signal names carry the _i/_o suffixes as seen from the initiator.
//
//   modport master : the wb_cmd_master block itself
//   modport slave  : whatever sits around it (command source, response sink
//                    and the Wishbone responder)
//
//   Command  : cmd_valid_i, cmd_ready_o, cmd_we_i, cmd_adr_i[31:0],
//              cmd_dat_i[31:0], cmd_sel_i[3:0]
//   Response : rsp_valid_o, rsp_ready_i, rsp_dat_o[31:0], rsp_err_o
//   Wishbone : wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o[3:0],
//              wbm_adr_o[31:0], wbm_dat_o[31:0], wbm_ack_i, wbm_dat_i[31:0]
// ---------------------------------------------------------------------------
interface wb_cmd_master_if;
  // command port
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_adr_i;
  logic [31:0] cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  // response port
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  // wishbone initiator
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output cmd_ready_o,
    input  rsp_ready_i,
    output rsp_valid_o, rsp_dat_o, rsp_err_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  cmd_ready_o,
    output rsp_ready_i,
    input  rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i
  );
endinterface

// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------
// wb_cmd_master
//   Wishbone classic initiator. Takes one single-word command at a time from
//   a valid/ready command port, runs one Wishbone cycle, and returns read
//   data (or write completion) on a valid/ready response port. No
//   pipelining: at most one transaction is in flight.
//
//   Ports
//     wb_clk_i   : clock, rising edge
//     wb_rst_n_i : asynchronous active-low reset
//     bus        : wb_cmd_master_if.master (command, response, Wishbone)
//
//   Parameters
//     TIMEOUT : stb cycles to wait for ack before aborting (2..65535)
//     TO_W    : timeout counter width, 2**TO_W > TIMEOUT
//
//   Optional feature
//     WBM_TIMEOUT_EN : when defined, a watchdog aborts a bus cycle that sees
//                      no ack for TIMEOUT edges and reports rsp_err_o = 1.
//                      When undefined, BUS waits forever, rsp_err_o is 0 and
//                      TIMEOUT/TO_W have no effect.
// ---------------------------------------------------------------------------
module wb_cmd_master #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 16
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_n_i,
  wb_cmd_master_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  logic [1:0]  state_q;
  wb_req_t     req_q;
  logic [31:0] rsp_dat_q;

  logic in_idle, in_bus, in_resp;
  logic accept;      // command handshake this cycle
  logic bus_ack;     // ack only counts while a cycle is open
  logic timeout_hit; // watchdog expires on this edge (never wins over ack)

  assign in_idle = (state_q == ST_IDLE);
  assign in_bus  = (state_q == ST_BUS);
  assign in_resp = (state_q == ST_RESP);
  assign accept  = in_idle & bus.cmd_valid_i;
  assign bus_ack = in_bus & bus.wbm_ack_i;

  // -------------------------------------------------------------------------
  // Main FSM. cyc/stb and rsp_valid are decoded from the state register, so
  // the asynchronous reset drops them at once rather than at the next edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      rsp_dat_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            req_q.we  <= bus.cmd_we_i;
            req_q.sel <= bus.cmd_sel_i;
            req_q.adr <= bus.cmd_adr_i;
            req_q.dat <= bus.cmd_dat_i;
            state_q   <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (bus_ack) begin
            rsp_dat_q <= req_q.we ? 32'h0 : bus.wbm_dat_i;
            state_q   <= ST_RESP;
          end else if (timeout_hit) begin
            rsp_dat_q <= 32'h0;
            state_q   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef WBM_TIMEOUT_EN
  // -------------------------------------------------------------------------
  // Watchdog. The counter holds the number of stb edges already seen without
  // ack, so the TIMEOUT-th such edge is the one where it equals TIMEOUT-1.
  // -------------------------------------------------------------------------
  logic [TO_W-1:0] to_cnt_q;
  logic            rsp_err_q;

  assign timeout_hit = in_bus & (to_cnt_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      to_cnt_q <= '0;
    end else if (accept) begin
      to_cnt_q <= '0;
    end else if (in_bus && !bus_ack) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rsp_err_q <= 1'b0;
    end else if (bus_ack) begin
      rsp_err_q <= 1'b0;
    end else if (timeout_hit) begin
      rsp_err_q <= 1'b1;
    end
  end

  assign bus.rsp_err_o = rsp_err_q;
`else
  // No watchdog: BUS only leaves on ack, errors cannot occur.
  logic unused_cfg;
  assign unused_cfg    = ^{TIMEOUT, TO_W};
  assign timeout_hit   = 1'b0;
  assign bus.rsp_err_o = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Outputs. stb mirrors cyc (single-beat classic cycles). we is masked in
  // IDLE so a finished write never looks like a pending one; adr/dat/sel
  // simply keep the last command.
  // -------------------------------------------------------------------------
  assign bus.cmd_ready_o = in_idle;
  assign bus.rsp_valid_o = in_resp;
  assign bus.rsp_dat_o   = rsp_dat_q;
  assign bus.wbm_cyc_o   = in_bus;
  assign bus.wbm_stb_o   = in_bus;
  assign bus.wbm_we_o    = req_q.we & ~in_idle;
  assign bus.wbm_sel_o   = req_q.sel;
  assign bus.wbm_adr_o   = req_q.adr;
  assign bus.wbm_dat_o   = req_q.dat;

endmodule

// File: tb/tb_wb_cmd_master.sv
module tb_wb_cmd_master;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  wb_cmd_master_if bus ();

  wb_cmd_master #(.TIMEOUT(4), .TO_W(3)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          waits;   // wait cycles before the slave acks
    logic [31:0] rdata;   // data the slave returns with ack
    logic [31:0] exp_rsp; // expected rsp_dat_o
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic consume();
    bus.rsp_ready_i = 1'b1;
    step();
    bus.rsp_ready_i = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_dat_i   = dat;
    bus.cmd_sel_i   = sel;
    step();
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = ~we;
    bus.cmd_adr_i   = ~adr;
    bus.cmd_dat_i   = ~dat;
    bus.cmd_sel_i   = ~sel;
  endtask

  task automatic do_txn(input vec_t v);
    chk("idle_ready", bus.cmd_ready_o, 1);
    issue(v.we, v.adr, v.dat, v.sel);
    chk("cyc_up",    bus.wbm_cyc_o, 1);
    chk("stb_up",    bus.wbm_stb_o, 1);
    chk("bus_we",    bus.wbm_we_o, v.we);
    chk("bus_adr",   bus.wbm_adr_o, v.adr);
    chk("bus_dat",   bus.wbm_dat_o, v.dat);
    chk("bus_sel",   bus.wbm_sel_o, v.sel);
    chk("busy_rdy",  bus.cmd_ready_o, 0);
    chk("busy_rsp",  bus.rsp_valid_o, 0);
    for (int w = 0; w < v.waits; w++) begin
      step();
      chk("wait_cyc", bus.wbm_cyc_o, 1);
      chk("wait_rsp", bus.rsp_valid_o, 0);
    end
    bus.wbm_ack_i = 1'b1;
    bus.wbm_dat_i = v.rdata;
    step();
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = 32'h0BAD_0BAD;
    chk("ack_cyc",   bus.wbm_cyc_o, 0);
    chk("rsp_valid", bus.rsp_valid_o, 1);
    chk("rsp_dat",   bus.rsp_dat_o, v.exp_rsp);
    chk("rsp_err",   bus.rsp_err_o, 0);
    consume();
    chk("done_rsp",  bus.rsp_valid_o, 0);
    chk("done_rdy",  bus.cmd_ready_o, 1);
    chk("idle_we",   bus.wbm_we_o, 0);
    chk("keep_dat",  bus.wbm_dat_o, v.dat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0;
    checks = 0;
    //          we    adr           dat           sel   w  rdata         exp
    vecs[0] = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1, 32'hAAAA_5555, 32'h0};
    vecs[1] = '{1'b0, 32'h3000_0008, 32'h0000_0000, 4'hF, 0, 32'h1234_5678, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'h3000_0010, 32'hCAFE_F00D, 4'h3, 2, 32'h8765_4321, 32'h8765_4321};
    vecs[3] = '{1'b1, 32'h3000_00FC, 32'h0000_0001, 4'h1, 0, 32'hFFFF_FFFF, 32'h0};
    vecs[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'hC, 1, 32'hA5A5_0F0F, 32'hA5A5_0F0F};
    vecs[5] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h8, 2, 32'h1111_1111, 32'h0};

    rst_n = 1'b0;
    bus.cmd_valid_i = 1'b0; bus.cmd_we_i = 1'b0; bus.cmd_adr_i = '0;
    bus.cmd_dat_i = '0; bus.cmd_sel_i = '0; bus.rsp_ready_i = 1'b0;
    bus.wbm_ack_i = 1'b0; bus.wbm_dat_i = '0;

    // reset state
    step(); step();
    chk("rst_ready", bus.cmd_ready_o, 1);
    chk("rst_rspv",  bus.rsp_valid_o, 0);
    chk("rst_err",   bus.rsp_err_o, 0);
    chk("rst_cyc",   bus.wbm_cyc_o, 0);
    chk("rst_stb",   bus.wbm_stb_o, 0);
    chk("rst_we",    bus.wbm_we_o, 0);
    chk("rst_rdat",  bus.rsp_dat_o, 0);
    chk("rst_adr",   bus.wbm_adr_o, 0);
    chk("rst_dat",   bus.wbm_dat_o, 0);
    chk("rst_sel",   bus.wbm_sel_o, 0);
    rst_n = 1'b1;
    step();

    // table of single transactions
    for (int i = 0; i < 6; i++) do_txn(vecs[i]);

    // backpressure: response held 5 cycles while a second command waits
    issue(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    bus.wbm_ack_i = 1'b1; bus.wbm_dat_i = 32'h5A5A_1234;
    step();
    bus.wbm_ack_i = 1'b0; bus.wbm_dat_i = 32'h0;
    bus.cmd_valid_i = 1'b1; bus.cmd_we_i = 1'b1;
    bus.cmd_adr_i = 32'h3000_0024; bus.cmd_dat_i = 32'h1111_2222; bus.cmd_sel_i = 4'hF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_rspv", bus.rsp_valid_o, 1);
      chk("bp_rdat", bus.rsp_dat_o, 32'h5A5A_1234);
      chk("bp_rdy",  bus.cmd_ready_o, 0);
      chk("bp_cyc",  bus.wbm_cyc_o, 0);
    end
    consume();
    chk("bp_free_rspv", bus.rsp_valid_o, 0);
    chk("bp_free_cyc",  bus.wbm_cyc_o, 0);
    chk("bp_free_rdy",  bus.cmd_ready_o, 1);
    step();
    bus.cmd_valid_i = 1'b0;
    chk("bp2_cyc", bus.wbm_cyc_o, 1);
    chk("bp2_adr", bus.wbm_adr_o, 32'h3000_0024);
    chk("bp2_we",  bus.wbm_we_o, 1);
    bus.wbm_ack_i = 1'b1;
    step();
    bus.wbm_ack_i = 1'b0;
    chk("bp2_rspv", bus.rsp_valid_o, 1);
    chk("bp2_rdat", bus.rsp_dat_o, 32'h0);
    consume();

    // stray ack in IDLE
    bus.wbm_ack_i = 1'b1; bus.wbm_dat_i = 32'hFFFF_0000;
    step(); step();
    bus.wbm_ack_i = 1'b0;
    chk("stray_idle_rdy",  bus.cmd_ready_o, 1);
    chk("stray_idle_cyc",  bus.wbm_cyc_o, 0);
    chk("stray_idle_rspv", bus.rsp_valid_o, 0);
    chk("stray_idle_rdat", bus.rsp_dat_o, 32'h0);

    // ack held high from BUS into RESP and beyond counts once
    issue(1'b0, 32'h3000_0030, 32'h0, 4'hF);
    step();
    bus.wbm_ack_i = 1'b1; bus.wbm_dat_i = 32'h0F0F_F0F0;
    step();
    bus.wbm_dat_i = 32'hDEAD_0000;
    step();
    chk("stray_resp_rspv", bus.rsp_valid_o, 1);
    chk("stray_resp_rdat", bus.rsp_dat_o, 32'h0F0F_F0F0);
    chk("stray_resp_cyc",  bus.wbm_cyc_o, 0);
    consume();
    step();
    chk("stray_after_rspv", bus.rsp_valid_o, 0);
    chk("stray_after_cyc",  bus.wbm_cyc_o, 0);
    chk("stray_after_rdat", bus.rsp_dat_o, 32'h0F0F_F0F0);
    bus.wbm_ack_i = 1'b0; bus.wbm_dat_i = 32'h0;

    // async reset in the middle of a read's bus cycle
    issue(1'b0, 32'h3000_0040, 32'h0, 4'hF);
    chk("ar_cyc_before", bus.wbm_cyc_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cyc", bus.wbm_cyc_o, 0);
    chk("ar_stb", bus.wbm_stb_o, 0);
    chk("ar_rspv", bus.rsp_valid_o, 0);
    chk("ar_rdy", bus.cmd_ready_o, 1);
    chk("ar_adr", bus.wbm_adr_o, 0);
    #2 rst_n = 1'b1;
    step();
    chk("ar_post_rdy", bus.cmd_ready_o, 1);
    chk("ar_post_cyc", bus.wbm_cyc_o, 0);
    do_txn(vecs[0]);

    // async reset while a response is waiting
    issue(1'b0, 32'h3000_0044, 32'h0, 4'hF);
    bus.wbm_ack_i = 1'b1; bus.wbm_dat_i = 32'h4444_4444;
    step();
    bus.wbm_ack_i = 1'b0;
    chk("ar2_rspv_before", bus.rsp_valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar2_rspv", bus.rsp_valid_o, 0);
    chk("ar2_rdat", bus.rsp_dat_o, 0);
    #2 rst_n = 1'b1;
    step();
    chk("ar2_rdy", bus.cmd_ready_o, 1);

`ifdef WBM_TIMEOUT_EN
    begin
      int n;
      // leave a nonzero response data behind first
      do_txn(vecs[2]);
      issue(1'b0, 32'h3000_0050, 32'h0, 4'hF);
      n = 0;
      for (int i = 0; i < 10; i++) begin
        if (!bus.wbm_cyc_o) break;
        n++;
        step();
      end
      chk("to_cyc_cycles", n, 4);
      chk("to_rspv", bus.rsp_valid_o, 1);
      chk("to_err",  bus.rsp_err_o, 1);
      chk("to_rdat", bus.rsp_dat_o, 32'h0);
      consume();
      // ack on the 4th edge beats the timeout
      issue(1'b0, 32'h3000_0054, 32'h0, 4'hF);
      step(); step(); step();
      chk("to4_cyc", bus.wbm_cyc_o, 1);
      bus.wbm_ack_i = 1'b1; bus.wbm_dat_i = 32'h7777_0001;
      step();
      bus.wbm_ack_i = 1'b0;
      chk("to4_rspv", bus.rsp_valid_o, 1);
      chk("to4_err",  bus.rsp_err_o, 0);
      chk("to4_rdat", bus.rsp_dat_o, 32'h7777_0001);
      consume();
    end
`else
    // without the watchdog a slow slave is simply waited for
    issue(1'b0, 32'h3000_0060, 32'h0, 4'hF);
    repeat (12) step();
    chk("slow_cyc",  bus.wbm_cyc_o, 1);
    chk("slow_rspv", bus.rsp_valid_o, 0);
    bus.wbm_ack_i = 1'b1; bus.wbm_dat_i = 32'h6060_6060;
    step();
    bus.wbm_ack_i = 1'b0;
    chk("slow_rspv2", bus.rsp_valid_o, 1);
    chk("slow_err",   bus.rsp_err_o, 0);
    chk("slow_rdat",  bus.rsp_dat_o, 32'h6060_6060);
    consume();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
